// File: rtl/sti_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sti_pkg
// Brief    : Shared types and helpers for the STI serial receiver.
// Revision : 1.0 - initial release
// ============================================================================
package sti_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [1:0] LEN_8  = 2'b00;
   localparam logic [1:0] LEN_16 = 2'b01;
   localparam logic [1:0] LEN_24 = 2'b10;
   localparam logic [1:0] LEN_32 = 2'b11;

   function automatic logic [5:0] len_bits(input logic [1:0] cfg_length);
      case (cfg_length)
         LEN_8:   len_bits = 6'd8;
         LEN_16:  len_bits = 6'd16;
         LEN_24:  len_bits = 6'd24;
         default: len_bits = 6'd32;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/sti_rx_unpack.sv
`default_nettype none
// ============================================================================
// Module   : sti_rx_unpack
// Brief    : Combinational extraction of the 16-bit word and pad check.
// Revision : 1.0 - initial release
// ============================================================================
module sti_rx_unpack
   import sti_pkg::*;
(
   input  logic [31:0] win,
   input  logic [1:0]  len,
   input  logic        fill,
   input  logic        low,
   output logic [15:0] word,
   output logic        pad_err
);

   always_comb begin
      word    = 16'h0000;
      pad_err = 1'b0;
      case (len)
         LEN_8: begin
            word = low ? {win[7:0], 8'h00} : {8'h00, win[7:0]};
         end
         LEN_16: begin
            word = win[15:0];
         end
         LEN_24: begin
            word    = fill ? win[23:8] : win[15:0];
            pad_err = fill ? (|win[7:0]) : (|win[23:16]);
         end
         default: begin
            word    = fill ? win[31:16] : win[15:0];
            pad_err = fill ? (|win[15:0]) : (|win[31:16]);
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/sti_rx.sv
`default_nettype none
// ============================================================================
// Module   : sti_rx
// Brief    : STI serial-to-parallel receiver with framing/pad error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module sti_rx
   import sti_pkg::*;
#(
   parameter int FRAME_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   si_data,
   input  logic                   si_valid,
   input  logic [1:0]             cfg_length,
   input  logic                   cfg_msb,
   input  logic                   cfg_fill,
   input  logic                   cfg_low,
   output logic [15:0]            po_data,
   output logic                   po_valid,
   output logic                   po_err,
   output logic                   po_pad_err,
   output logic                   po_busy,
   output logic [FRAME_CNT_W-1:0] po_frames
);

   localparam logic [FRAME_CNT_W-1:0] c_frame_one = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_win;
   logic [5:0]  r_cnt;
   logic [1:0]  r_len;
   logic        r_msb;
   logic        r_fill;
   logic        r_low;
   logic [5:0]  w_n;
   logic        w_start;
   logic        w_store;
   logic        w_good;
   logic        w_err;
   logic [15:0] w_word;
   logic        w_pad;

   assign w_n     = len_bits(r_len);
   assign po_busy = (r_state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_store = 1'b0;
      w_good  = 1'b0;
      w_err   = 1'b0;
      case (r_state)
         IDLE: begin
            if (si_valid) begin
               w_start = 1'b1;
               w_next  = RECV;
            end
         end
         RECV: begin
            if (si_valid) begin
               if (r_cnt < w_n) begin
                  w_store = 1'b1;
               end else begin
                  w_err  = 1'b1;
                  w_next = FLUSH;
               end
            end else begin
               w_good = (r_cnt == w_n);
               w_err  = (r_cnt != w_n);
               w_next = IDLE;
            end
         end
         FLUSH: begin
            if (!si_valid) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Datapath: window, bit counter, latched config and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_win      <= 32'h0;
         r_cnt      <= 6'd0;
         r_len      <= LEN_8;
         r_msb      <= 1'b0;
         r_fill     <= 1'b0;
         r_low      <= 1'b0;
         po_data    <= 16'h0000;
         po_valid   <= 1'b0;
         po_err     <= 1'b0;
         po_pad_err <= 1'b0;
         po_frames  <= '0;
      end else begin
         po_valid   <= w_good;
         po_err     <= w_err;
         po_pad_err <= w_good & w_pad;
         if (w_start) begin
            r_len  <= cfg_length;
            r_msb  <= cfg_msb;
            r_fill <= cfg_fill;
            r_low  <= cfg_low;
            r_win  <= {31'h0, si_data};
            r_cnt  <= 6'd1;
         end
         if (w_store) begin
            if (r_msb) r_win <= {r_win[30:0], si_data};
            else       r_win[r_cnt[4:0]] <= si_data;
            r_cnt <= r_cnt + 6'd1;
         end
         if (w_good) begin
            po_data <= w_word;
            if (po_frames != {FRAME_CNT_W{1'b1}}) po_frames <= po_frames + c_frame_one;
         end
      end
   end

   sti_rx_unpack u_unpack (
      .win     (r_win),
      .len     (r_len),
      .fill    (r_fill),
      .low     (r_low),
      .word    (w_word),
      .pad_err (w_pad)
   );

endmodule
`default_nettype wire

// File: tb/tb_sti_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sti_rx
// Brief    : Directed self-checking bench for the STI serial receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sti_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        si_data = 1'b0;
   logic        si_valid = 1'b0;
   logic [1:0]  cfg_length = 2'b00;
   logic        cfg_msb = 1'b0;
   logic        cfg_fill = 1'b0;
   logic        cfg_low = 1'b0;
   logic [15:0] po_data;
   logic        po_valid;
   logic        po_err;
   logic        po_pad_err;
   logic        po_busy;
   logic [2:0]  po_frames;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sti_rx #(.FRAME_CNT_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .si_data    (si_data),
      .si_valid   (si_valid),
      .cfg_length (cfg_length),
      .cfg_msb    (cfg_msb),
      .cfg_fill   (cfg_fill),
      .cfg_low    (cfg_low),
      .po_data    (po_data),
      .po_valid   (po_valid),
      .po_err     (po_err),
      .po_pad_err (po_pad_err),
      .po_busy    (po_busy),
      .po_frames  (po_frames)
   );

   // Sends window bits win[n-1:0]; cfg is scrambled after bit 0 to prove it is latched.
   task automatic drive_frame(input logic [31:0] win, input int n, input logic [1:0] len,
                              input logic msb, input logic fill, input logic low);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         si_valid = 1'b1;
         si_data  = msb ? win[n-1-i] : win[i];
         if (i == 0) begin
            cfg_length = len; cfg_msb = msb; cfg_fill = fill; cfg_low = low;
         end else if (i == 1) begin
            cfg_length = ~len; cfg_msb = ~msb; cfg_fill = ~fill; cfg_low = ~low;
         end
      end
      @(negedge clk);
      si_valid = 1'b0;
      si_data  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      si_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (po_data !== 16'h0) $display("FAIL reset_data: got %h want 0000", po_data); else n_pass++;
      n_checks++; if ({po_valid, po_err, po_pad_err, po_busy} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {po_valid, po_err, po_pad_err, po_busy}); else n_pass++;
      n_checks++; if (po_frames !== 3'd0) $display("FAIL reset_frames: got %0d want 0", po_frames); else n_pass++;
   endtask

   task automatic test_16_msb();
      @(negedge clk);
      drive_frame(32'h0000A5C3, 16, 2'b01, 1'b1, 1'b0, 1'b0);
      n_checks++; if (po_busy !== 1'b1) $display("FAIL m16_busy: got %b want 1", po_busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (po_valid !== 1'b1) $display("FAIL m16_valid: got %b want 1", po_valid); else n_pass++;
      n_checks++; if (po_data !== 16'hA5C3) $display("FAIL m16_data: got %h want a5c3", po_data); else n_pass++;
      n_checks++; if (po_pad_err !== 1'b0) $display("FAIL m16_pad: got %b want 0", po_pad_err); else n_pass++;
      n_checks++; if (po_frames !== 3'd1) $display("FAIL m16_frames: got %0d want 1", po_frames); else n_pass++;
      n_checks++; if (po_err !== 1'b0) $display("FAIL m16_err: got %b want 0", po_err); else n_pass++;
      @(negedge clk);
      n_checks++; if (po_valid !== 1'b0) $display("FAIL m16_pulse: got %b want 0", po_valid); else n_pass++;
      n_checks++; if (po_busy !== 1'b0) $display("FAIL m16_idle: got %b want 0", po_busy); else n_pass++;
   endtask

   task automatic test_8bit();
      @(negedge clk);
      drive_frame(32'h0000003C, 8, 2'b00, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++; if (po_valid !== 1'b1 || po_data !== 16'h3C00) $display("FAIL b8_low: got v=%b %h want v=1 3c00", po_valid, po_data); else n_pass++;
      @(negedge clk);
      drive_frame(32'h0000003C, 8, 2'b00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++; if (po_valid !== 1'b1 || po_data !== 16'h003C) $display("FAIL b8_high: got v=%b %h want v=1 003c", po_valid, po_data); else n_pass++;
      n_checks++; if (po_frames !== 3'd3) $display("FAIL b8_frames: got %0d want 3", po_frames); else n_pass++;
   endtask

   task automatic test_24bit();
      @(negedge clk);
      drive_frame(32'h00001234, 24, 2'b10, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++; if (po_data !== 16'h1234 || po_pad_err !== 1'b0) $display("FAIL b24_clean: got %h pad=%b want 1234 pad=0", po_data, po_pad_err); else n_pass++;
      @(negedge clk);
      drive_frame(32'h00801234, 24, 2'b10, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++; if (po_data !== 16'h1234 || po_pad_err !== 1'b1 || po_valid !== 1'b1) $display("FAIL b24_pad: got %h pad=%b v=%b want 1234 pad=1 v=1", po_data, po_pad_err, po_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (po_pad_err !== 1'b0) $display("FAIL b24_pad_pulse: got %b want 0", po_pad_err); else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      @(negedge clk);
      drive_frame(32'hBEEF0000, 32, 2'b11, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++; if (po_valid !== 1'b1 || po_data !== 16'hBEEF || po_pad_err !== 1'b0) $display("FAIL b2b_first: got v=%b %h pad=%b want v=1 beef pad=0", po_valid, po_data, po_pad_err); else n_pass++;
      drive_frame(32'h13570000, 32, 2'b11, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++; if (po_valid !== 1'b1 || po_data !== 16'h1357) $display("FAIL b2b_second: got v=%b %h want v=1 1357", po_valid, po_data); else n_pass++;
      n_checks++; if (po_frames !== 3'd2) $display("FAIL b2b_frames: got %0d want 2", po_frames); else n_pass++;
   endtask

   task automatic test_short();
      @(negedge clk);
      drive_frame(32'h000003FF, 10, 2'b01, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++; if (po_err !== 1'b1 || po_valid !== 1'b0) $display("FAIL short_err: got err=%b v=%b want err=1 v=0", po_err, po_valid); else n_pass++;
      n_checks++; if (po_data !== 16'h1357 || po_frames !== 3'd2) $display("FAIL short_hold: got %h f=%0d want 1357 f=2", po_data, po_frames); else n_pass++;
      @(negedge clk);
      n_checks++; if (po_err !== 1'b0) $display("FAIL short_pulse: got %b want 0", po_err); else n_pass++;
   endtask

   task automatic test_overrun();
      cfg_length = 2'b01; cfg_msb = 1'b1; cfg_fill = 1'b0; cfg_low = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 17) begin
            n_checks++; if (po_err !== 1'b1 || po_valid !== 1'b0) $display("FAIL ovr_err: got err=%b v=%b want err=1 v=0", po_err, po_valid); else n_pass++;
         end
         if (i == 16) begin
            n_checks++; if (po_err !== 1'b0) $display("FAIL ovr_early: got %b want 0", po_err); else n_pass++;
         end
         if (i == 18) begin
            n_checks++; if (po_err !== 1'b0 || po_busy !== 1'b1) $display("FAIL ovr_flush: got err=%b busy=%b want err=0 busy=1", po_err, po_busy); else n_pass++;
         end
         si_valid = 1'b1;
         si_data  = i[0];
      end
      @(negedge clk);
      si_valid = 1'b0;
      @(negedge clk);
      n_checks++; if ({po_busy, po_err, po_valid} !== 3'b000) $display("FAIL ovr_end: got busy/err/v=%b want 000", {po_busy, po_err, po_valid}); else n_pass++;
      n_checks++; if (po_frames !== 3'd2 || po_data !== 16'h1357) $display("FAIL ovr_hold: got f=%0d %h want f=2 1357", po_frames, po_data); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [15:0] w;
      w = 16'hA5C3;
      cfg_length = 2'b01; cfg_msb = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         si_valid = 1'b1;
         si_data  = w[15-i];
      end
      @(negedge clk);
      reset = 1'b1;
      si_data = w[3];
      @(negedge clk);
      reset = 1'b0;
      si_valid = 1'b0;
      n_checks++; if ({po_busy, po_err, po_valid, po_pad_err} !== 4'b0 || po_data !== 16'h0 || po_frames !== 3'd0) $display("FAIL midrst_state: got flags=%b %h f=%0d want 0000 0000 f=0", {po_busy, po_err, po_valid, po_pad_err}, po_data, po_frames); else n_pass++;
      @(negedge clk);
      n_checks++; if (po_err !== 1'b0 || po_valid !== 1'b0) $display("FAIL midrst_pulse: got err=%b v=%b want 0 0", po_err, po_valid); else n_pass++;
      drive_frame(32'h0000A5C3, 16, 2'b01, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++; if (po_valid !== 1'b1 || po_data !== 16'hA5C3 || po_frames !== 3'd1) $display("FAIL midrst_clean: got v=%b %h f=%0d want v=1 a5c3 f=1", po_valid, po_data, po_frames); else n_pass++;
   endtask

   task automatic test_saturate();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 7) begin
            n_checks++; if (po_frames !== 3'd7) $display("FAIL sat_seven: got %0d want 7", po_frames); else n_pass++;
         end
         drive_frame(32'h00000011 + k, 8, 2'b00, 1'b1, 1'b0, 1'b0);
      end
      @(negedge clk);
      n_checks++; if (po_frames !== 3'd7 || po_data !== 16'h0018) $display("FAIL sat_hold: got f=%0d %h want f=7 0018", po_frames, po_data); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_16_msb();
      test_8bit();
      test_24bit();
      test_back_to_back();
      test_short();
      test_overrun();
      test_reset_mid();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sti_rx.md
# sti_rx

Serial-to-parallel receiver for the STI single-bit stream: the receive end of the link that carries `so_data`/`so_valid`. It deserialises each frame of 8/16/24/32 bits back into the original 16-bit parallel word, using the same length/fill/msb/low conventions as the transmitter. It reports framing and pad errors and keeps a frame count. It sits between the serial link and any consumer of parallel words, such as a loop-back checker or a memory writer.

## Interface
- `FRAME_CNT_W`, default 8: width of the saturating good-frame counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `si_data`  in  1  serial bit; sampled only when `si_valid`=1.
- `si_valid`  in  1  frame strobe; one frame is a contiguous run of 1s.
- `cfg_length`  in  2  frame length: 00=8, 01=16, 10=24, 11=32 bits. Latched on the first bit of a frame.
- `cfg_msb`  in  1  1 = MSB-first order, 0 = LSB-first. Latched with `cfg_length`.
- `cfg_fill`  in  1  24/32-bit placement: 1 = data in the upper field. Latched.
- `cfg_low`  in  1  8-bit mode: 1 = byte belongs in `po_data[15:8]`. Latched.
- `po_data`  out  16  recovered word; holds its value until the next good frame.
- `po_valid`  out  1  one-cycle pulse marking a good frame.
- `po_err`  out  1  one-cycle pulse for a short or overrun frame.
- `po_pad_err`  out  1  valid with `po_valid`: a non-data bit of the frame was 1.
- `po_busy`  out  1  high in RECV and FLUSH.
- `po_frames`  out  `FRAME_CNT_W`  count of good frames; saturates at all-ones.

## Operation
- **Frame window.** W[31:0] holds the N transmitted bits in W[N-1:0].
  - MSB-first: each bit shifts in at the bottom, `W <= {W[30:0], bit}`, so the first bit received ends up as W[N-1].
  - LSB-first: the bit at count k is written to W[k], so the first bit received is W[0].
- **States:** IDLE, RECV, FLUSH.
- **IDLE.**
  - `si_valid`=1: latch the cfg inputs, clear W, store bit 0, set count=1, go to RECV.
- **RECV.**
  - `si_valid`=1 and count<N: store the bit, count++.
  - `si_valid`=1 and count==N: overrun. Pulse `po_err` and go to FLUSH.
  - `si_valid`=0 and count==N: good frame. Update `po_data`, pulse `po_valid`, set `po_pad_err`, increment `po_frames`, go to IDLE.
  - `si_valid`=0 and count<N: short frame. Pulse `po_err`, go to IDLE; `po_data` is unchanged.
- **FLUSH.** Discard bits while `si_valid`=1. On `si_valid`=0 go to IDLE with no further pulse.
- **Extraction.** "Pad" means the bits of W[N-1:0] outside the data field.

  | `cfg_length` | Condition | `po_data` | Pad bits |
  |---|---|---|---|
  | 00 (8) | `cfg_low`=1 | {W[7:0], 8'h00} | none |
  | 00 (8) | `cfg_low`=0 | {8'h00, W[7:0]} | none |
  | 01 (16) | — | W[15:0] | none |
  | 10 (24) | `cfg_fill`=1 | W[23:8] | W[7:0] |
  | 10 (24) | `cfg_fill`=0 | W[15:0] | W[23:16] |
  | 11 (32) | `cfg_fill`=1 | W[31:16] | W[15:0] |
  | 11 (32) | `cfg_fill`=0 | W[15:0] | W[31:16] |

- **Counter widths.** The bit counter is 6 bits wide, so N=32 is representable. `po_frames` does not wrap.

## Timing
- **Reset values.** Reset forces IDLE and all outputs to 0: `po_data`=0, `po_valid`=0, `po_err`=0, `po_pad_err`=0, `po_busy`=0, `po_frames`=0. W and count are cleared. Reset takes effect at the next edge, including mid-frame; the partial frame is lost and produces no pulse.
- **Output latency.** The last bit is sampled at edge k and the low `si_valid` at edge k+1. `po_valid` (or `po_err` for a short frame) is high for exactly the cycle after edge k+1. An overrun `po_err` appears the cycle after the edge that sampled bit N+1.
- **Back-to-back frames.** A minimum gap of 1 cycle with `si_valid`=0 is required. A new frame may start on the cycle `po_valid` is high; IDLE accepts it at that same edge.
- **Configuration.** cfg changes in mid-frame are ignored.
- **Simultaneous pulses.** `po_valid` and `po_err` are never high together.

## Structure
- **Package `sti_pkg`.**
  - State enum: IDLE, RECV, FLUSH.
  - Length encodings: LEN_8, LEN_16, LEN_24, LEN_32.
  - Function `len_bits(cfg_length)` returning N.
- **Sub-module `sti_rx_unpack`.** Purely combinational: (W, latched cfg) -> (word, pad_err). The top level keeps the FSM, counters and output registers.

## Test plan
- 16-bit frame, `cfg_msb`=1, bits of 0xA5C3 sent MSB-first -> `po_data`=0xA5C3, `po_valid` high 1 cycle, `po_frames`=1, `po_pad_err`=0.
- 8-bit frame, `cfg_msb`=0, `cfg_low`=1, byte 0x3C sent LSB-first -> `po_data`=0x3C00. Repeat with `cfg_low`=0 -> `po_data`=0x003C.
- 24-bit frame, `cfg_fill`=0, `cfg_msb`=1, window 0x001234 -> `po_data`=0x1234, `po_pad_err`=0. Window 0x801234 -> `po_data`=0x1234, `po_pad_err`=1.
- 32-bit frame, `cfg_fill`=1, LSB-first, window 0xBEEF0000 -> `po_data`=0xBEEF. Then a 1-cycle gap and a second 32-bit frame back-to-back -> two `po_valid` pulses, `po_frames`=2.
- `cfg_length`=01:
  - 10 bits -> `po_err` pulse, no `po_valid`, `po_data` unchanged.
  - 17 bits -> `po_err` the cycle after bit 17, `po_busy` stays high until `si_valid` falls, no `po_valid`.
- `reset` asserted at bit 12 of a 16-bit frame -> at the next edge all outputs are 0 and the FSM is in IDLE. The following clean frame decodes correctly.
